// File: rtl/bp_cce_mem_cmd_serializer_pkg.sv
// Shared types and helpers for the CCE memory-command serializer.
//
// Contents:
//   beat_width_gp          width of one serialized data beat (64)
//   paddr_width_gp         physical address width carried in the header
//   mem_payload_width_gp   width of the opaque header payload field
//   bp_cce_mem_cmd_type_e  memory command opcodes
//   bp_cce_mem_req_size_e  request size encodings (1B .. 64B)
//   bp_cce_mem_hdr_s       header layout; a full message is {block data, header}
//   mem_size_to_bytes()    size encoding -> byte count
//   mem_cmd_has_data()     true for opcodes that are followed by data beats
package bp_cce_mem_cmd_serializer_pkg;

  localparam int unsigned beat_width_gp        = 64;
  localparam int unsigned paddr_width_gp       = 40;
  localparam int unsigned mem_payload_width_gp = 16;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'd0,
    e_cce_mem_wr    = 4'd1,
    e_cce_mem_uc_rd = 4'd2,
    e_cce_mem_uc_wr = 4'd3,
    e_cce_mem_pre   = 4'd4,
    e_cce_mem_wb    = 4'd5
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [2:0] {
    e_mem_size_1  = 3'd0,
    e_mem_size_2  = 3'd1,
    e_mem_size_4  = 3'd2,
    e_mem_size_8  = 3'd3,
    e_mem_size_16 = 3'd4,
    e_mem_size_32 = 3'd5,
    e_mem_size_64 = 3'd6
  } bp_cce_mem_req_size_e;

  // Packed MSB-first: payload sits on top, msg_type in the low bits.
  typedef struct packed {
    logic [mem_payload_width_gp-1:0] payload;
    bp_cce_mem_req_size_e            size;
    logic [paddr_width_gp-1:0]       addr;
    bp_cce_mem_cmd_type_e            msg_type;
  } bp_cce_mem_hdr_s;

  function automatic int unsigned mem_size_to_bytes(input bp_cce_mem_req_size_e size);
    return 32'd1 << size;
  endfunction

  function automatic logic mem_cmd_has_data(input bp_cce_mem_cmd_type_e msg_type);
    return (msg_type == e_cce_mem_wb) || (msg_type == e_cce_mem_uc_wr);
  endfunction

endpackage

// File: rtl/bp_cce_mem_cmd_serializer_dff_en.sv
// Enabled register without reset, used to capture a whole memory command.
//
// Ports:
//   clk_i   clock
//   en_i    load enable; data_i is captured on the rising edge when high
//   data_i  value to capture
//   data_o  captured value
module bp_cce_mem_cmd_serializer_dff_en #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/bp_cce_mem_cmd_serializer.sv
// Serializes a full-block CCE memory command into a header followed by
// 64-bit data beats (only for opcodes that carry data).
//
// Ports:
//   clk_i             clock
//   reset_i           synchronous active-high reset
//   mem_cmd_i         full message {block data, header}
//   mem_cmd_v_i       command valid
//   mem_cmd_ready_o   command ready; high only while idle
//   mem_hdr_o         registered header
//   mem_hdr_v_o       header valid
//   mem_hdr_ready_i   header ready
//   mem_data_o        current data beat
//   mem_data_v_o      data beat valid
//   mem_data_last_o   current beat is the final one of the command
//   mem_data_ready_i  data ready
module bp_cce_mem_cmd_serializer
  import bp_cce_mem_cmd_serializer_pkg::*;
#(
  parameter bp_params_p = "inv",
  // "sml" selects the reduced-block configuration; everything else uses 512-bit blocks.
  localparam int unsigned cce_block_width_p    = (bp_params_p == "sml") ? 256 : 512,
  localparam int unsigned mem_hdr_width_lp     = $bits(bp_cce_mem_hdr_s),
  localparam int unsigned cce_mem_msg_width_lp = mem_hdr_width_lp + cce_block_width_p
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,

  input  logic [cce_mem_msg_width_lp-1:0]                   mem_cmd_i,
  input  logic                                              mem_cmd_v_i,
  output logic                                              mem_cmd_ready_o,

  output logic [cce_mem_msg_width_lp-cce_block_width_p-1:0] mem_hdr_o,
  output logic                                              mem_hdr_v_o,
  input  logic                                              mem_hdr_ready_i,

  output logic [63:0]                                       mem_data_o,
  output logic                                              mem_data_v_o,
  output logic                                              mem_data_last_o,
  input  logic                                              mem_data_ready_i
);

  localparam int unsigned beat_width_lp   = beat_width_gp;
  localparam int unsigned num_beats_lp    = cce_block_width_p / beat_width_lp;
  localparam int unsigned lg_num_beats_lp = (num_beats_lp > 1) ? $clog2(num_beats_lp) : 1;

  typedef enum logic [1:0] {
    e_idle = 2'd0,
    e_hdr  = 2'd1,
    e_data = 2'd2
  } state_e;

  state_e                                       state_q;
  logic                                         ready_q;
  logic                                         hdr_v_q;
  logic                                         data_v_q;
  logic [lg_num_beats_lp-1:0]                   cnt_q;

  logic                                         accept;
  logic [cce_mem_msg_width_lp-1:0]              msg_q;
  bp_cce_mem_hdr_s                              hdr_q;
  logic [num_beats_lp-1:0][beat_width_lp-1:0]   data_q;
  logic [lg_num_beats_lp-1:0]                   last_idx;
  logic                                         beat_last;
  logic                                         has_data;

  // ready_q is only ever set while idle, so it alone qualifies the accept.
  assign accept = mem_cmd_v_i & ready_q;

  bp_cce_mem_cmd_serializer_dff_en #(
    .width_p(cce_mem_msg_width_lp)
  ) u_msg_reg (
    .clk_i  (clk_i),
    .en_i   (accept),
    .data_i (mem_cmd_i),
    .data_o (msg_q)
  );

  assign hdr_q  = msg_q[mem_hdr_width_lp-1:0];
  assign data_q = msg_q[cce_mem_msg_width_lp-1:mem_hdr_width_lp];

  // Index of the final beat: max(1, bytes/8) beats, clamped to the block size.
  function automatic logic [lg_num_beats_lp-1:0] last_beat_idx(
    input bp_cce_mem_req_size_e size
  );
    int unsigned beats;
    beats = mem_size_to_bytes(size) / (beat_width_lp / 8);
    if (beats == 0) begin
      beats = 1;
    end
    if (beats > num_beats_lp) begin
      beats = num_beats_lp;
    end
    return lg_num_beats_lp'(beats - 1);
  endfunction

  assign last_idx  = last_beat_idx(hdr_q.size);
  assign beat_last = (cnt_q == last_idx);
  assign has_data  = mem_cmd_has_data(hdr_q.msg_type);

  // Control FSM with registered handshake outputs and the beat counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= e_idle;
      ready_q  <= 1'b0;
      hdr_v_q  <= 1'b0;
      data_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        e_idle: begin
          ready_q <= 1'b1;
          if (accept) begin
            state_q <= e_hdr;
            ready_q <= 1'b0;
            hdr_v_q <= 1'b1;
          end
        end
        e_hdr: begin
          if (hdr_v_q & mem_hdr_ready_i) begin
            hdr_v_q <= 1'b0;
            if (has_data) begin
              state_q  <= e_data;
              data_v_q <= 1'b1;
              cnt_q    <= '0;
            end else begin
              state_q <= e_idle;
              ready_q <= 1'b1;
            end
          end
        end
        e_data: begin
          if (data_v_q & mem_data_ready_i) begin
            if (beat_last) begin
              state_q  <= e_idle;
              data_v_q <= 1'b0;
              ready_q  <= 1'b1;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= e_idle;
          ready_q  <= 1'b0;
          hdr_v_q  <= 1'b0;
          data_v_q <= 1'b0;
          cnt_q    <= '0;
        end
      endcase
    end
  end

  assign mem_cmd_ready_o = ready_q;
  assign mem_hdr_o       = hdr_q;
  assign mem_hdr_v_o     = hdr_v_q;
  assign mem_data_o      = data_q[cnt_q];
  assign mem_data_v_o    = data_v_q;
  assign mem_data_last_o = data_v_q & beat_last;

endmodule

// File: tb/tb_bp_cce_mem_cmd_serializer.sv
module tb_bp_cce_mem_cmd_serializer;
  import bp_cce_mem_cmd_serializer_pkg::*;

  localparam int HW = $bits(bp_cce_mem_hdr_s);
  localparam int BW = 512;
  localparam int MW = HW + BW;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [MW-1:0] mem_cmd_i;
  logic          mem_cmd_v_i;
  logic          mem_cmd_ready_o;
  logic [HW-1:0] mem_hdr_o;
  logic          mem_hdr_v_o;
  logic          mem_hdr_ready_i;
  logic [63:0]   mem_data_o;
  logic          mem_data_v_o;
  logic          mem_data_last_o;
  logic          mem_data_ready_i;

  always #5 clk = ~clk;

  bp_cce_mem_cmd_serializer #(
    .bp_params_p("inv")
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .mem_cmd_i        (mem_cmd_i),
    .mem_cmd_v_i      (mem_cmd_v_i),
    .mem_cmd_ready_o  (mem_cmd_ready_o),
    .mem_hdr_o        (mem_hdr_o),
    .mem_hdr_v_o      (mem_hdr_v_o),
    .mem_hdr_ready_i  (mem_hdr_ready_i),
    .mem_data_o       (mem_data_o),
    .mem_data_v_o     (mem_data_v_o),
    .mem_data_last_o  (mem_data_last_o),
    .mem_data_ready_i (mem_data_ready_i)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] got_beats[$];

  typedef struct {
    bp_cce_mem_cmd_type_e t;
    bp_cce_mem_req_size_e sz;
    logic [39:0]          addr;
    logic [511:0]         data;
    int                   n;
    logic [63:0]          b0;
    logic [63:0]          blast;
    int                   pct;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: only wb/uc_wr carry data, max(1, bytes/8) beats.
  function automatic int model_beats(input bp_cce_mem_cmd_type_e t,
                                     input bp_cce_mem_req_size_e sz);
    int bytes;
    if (!(t == e_cce_mem_wb || t == e_cce_mem_uc_wr)) return 0;
    bytes = 1 << int'(sz);
    return (bytes < 8) ? 1 : bytes / 8;
  endfunction

  function automatic bp_cce_mem_hdr_s mk_hdr(input bp_cce_mem_cmd_type_e t,
                                             input bp_cce_mem_req_size_e sz,
                                             input logic [39:0] addr,
                                             input logic [15:0] payload);
    bp_cce_mem_hdr_s h;
    h.payload  = payload;
    h.size     = sz;
    h.addr     = addr;
    h.msg_type = t;
    return h;
  endfunction

  // Sends one command and checks header/beats; collected beats land in got_beats.
  task automatic send_cmd(input bp_cce_mem_hdr_s hdr, input logic [511:0] data,
                          input int n_exp, input int hdr_pct, input int data_pct);
    int   w;
    int   i;
    int   cyc;
    logic done;
    logic rdy;
    logic [63:0] cur;
    got_beats.delete();
    w = 0;
    while (!mem_cmd_ready_o && w < 20) begin
      step();
      w++;
    end
    chk("cmd_ready", 64'(mem_cmd_ready_o), 64'd1);
    mem_cmd_i   = {data, hdr};
    mem_cmd_v_i = 1'b1;
    step();
    mem_cmd_v_i = 1'b0;
    mem_cmd_i   = ~mem_cmd_i;
    chk("hdr_v_latency", 64'(mem_hdr_v_o), 64'd1);
    chk("hdr_fields", 64'(mem_hdr_o), 64'(hdr));
    chk("data_v_during_hdr", 64'(mem_data_v_o), 64'd0);
    chk("ready_busy", 64'(mem_cmd_ready_o), 64'd0);

    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 200) begin
      rdy = ($urandom_range(99) < hdr_pct);
      mem_hdr_ready_i = rdy;
      step();
      mem_hdr_ready_i = 1'b0;
      cyc++;
      if (rdy) done = 1'b1;
      else begin
        chk("hdr_hold_v", 64'(mem_hdr_v_o), 64'd1);
        chk("hdr_hold_data", 64'(mem_hdr_o), 64'(hdr));
      end
    end
    if (!done) chk("hdr_timeout", 64'd0, 64'd1);
    chk("hdr_v_after_hs", 64'(mem_hdr_v_o), 64'd0);

    if (n_exp == 0) begin
      chk("no_data_v", 64'(mem_data_v_o), 64'd0);
    end else begin
      i   = 0;
      cyc = 0;
      while (i < n_exp && cyc < 400) begin
        cur = data[64*i +: 64];
        chk("beat_v", 64'(mem_data_v_o), 64'd1);
        chk("beat_data", mem_data_o, cur);
        chk("beat_last", 64'(mem_data_last_o), 64'(i == n_exp - 1));
        chk("beat_no_hdr", 64'(mem_hdr_v_o), 64'd0);
        rdy = ($urandom_range(99) < data_pct);
        mem_data_ready_i = rdy;
        step();
        mem_data_ready_i = 1'b0;
        cyc++;
        if (rdy) begin
          got_beats.push_back(cur);
          i++;
        end
      end
      if (i < n_exp) chk("data_timeout", 64'(i), 64'(n_exp));
      chk("data_v_after", 64'(mem_data_v_o), 64'd0);
    end
    chk("ready_after", 64'(mem_cmd_ready_o), 64'd1);
  endtask

  function automatic void add_vec(input bp_cce_mem_cmd_type_e t, input bp_cce_mem_req_size_e sz,
                                  input logic [39:0] addr, input logic [511:0] data, input int n,
                                  input logic [63:0] b0, input logic [63:0] blast, input int pct);
    vec_t v;
    v.t = t; v.sz = sz; v.addr = addr; v.data = data; v.n = n;
    v.b0 = b0; v.blast = blast; v.pct = pct;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [511:0] pat;
    logic [511:0] rdat;
    logic [63:0]  a64;
    bp_cce_mem_cmd_type_e t;
    bp_cce_mem_req_size_e sz;
    int n;
    int w;

    for (int b = 0; b < 64; b++) pat[8*b +: 8] = 8'(b);

    reset_i = 1'b1; mem_cmd_v_i = 1'b0; mem_cmd_i = '0;
    mem_hdr_ready_i = 1'b0; mem_data_ready_i = 1'b0;
    repeat (3) step();
    chk("rst_ready", 64'(mem_cmd_ready_o), 64'd0);
    chk("rst_hdr_v", 64'(mem_hdr_v_o), 64'd0);
    chk("rst_data_v", 64'(mem_data_v_o), 64'd0);
    chk("rst_last", 64'(mem_data_last_o), 64'd0);
    reset_i = 1'b0;

    add_vec(e_cce_mem_rd,    e_mem_size_64, 40'h80_0000_0040, pat, 0, '0, '0, 100);
    add_vec(e_cce_mem_wb,    e_mem_size_64, 40'h80_0000_1000, pat, 8,
            64'h0706050403020100, 64'h3f3e3d3c3b3a3938, 100);
    add_vec(e_cce_mem_uc_wr, e_mem_size_4,  40'h80_0000_2004, 512'hDEADBEEF, 1,
            64'h00000000DEADBEEF, 64'h00000000DEADBEEF, 100);
    add_vec(e_cce_mem_wb,    e_mem_size_64, 40'h80_0000_3000, pat, 8,
            64'h0706050403020100, 64'h3f3e3d3c3b3a3938, 40);
    add_vec(e_cce_mem_uc_wr, e_mem_size_32, 40'h80_0000_4000, pat, 4,
            64'h0706050403020100, 64'h1f1e1d1c1b1a1918, 70);
    add_vec(e_cce_mem_uc_wr, e_mem_size_16, 40'h80_0000_5000, pat, 2,
            64'h0706050403020100, 64'h0f0e0d0c0b0a0908, 100);
    add_vec(e_cce_mem_uc_wr, e_mem_size_1,  40'h80_0000_6001, pat, 1,
            64'h0706050403020100, 64'h0706050403020100, 100);
    add_vec(e_cce_mem_uc_rd, e_mem_size_8,  40'h80_0000_7000, pat, 0, '0, '0, 60);
    add_vec(e_cce_mem_wr,    e_mem_size_64, 40'h80_0000_8000, pat, 0, '0, '0, 100);
    add_vec(e_cce_mem_pre,   e_mem_size_1,  40'h80_0000_9000, pat, 0, '0, '0, 100);

    foreach (vecs[k]) begin
      send_cmd(mk_hdr(vecs[k].t, vecs[k].sz, vecs[k].addr, 16'(k)), vecs[k].data,
               vecs[k].n, vecs[k].pct, vecs[k].pct);
      chk("vec_beat_count", 64'(got_beats.size()), 64'(vecs[k].n));
      if (vecs[k].n > 0 && got_beats.size() == vecs[k].n) begin
        chk("vec_beat0", got_beats[0], vecs[k].b0);
        chk("vec_beat_last", got_beats[vecs[k].n-1], vecs[k].blast);
      end
    end

    // Reset in the middle of a writeback, while beat 3 is on the bus.
    w = 0;
    while (!mem_cmd_ready_o && w < 20) begin step(); w++; end
    chk("mid_rst_ready", 64'(mem_cmd_ready_o), 64'd1);
    mem_cmd_i   = {pat, mk_hdr(e_cce_mem_wb, e_mem_size_64, 40'h80_0000_a000, 16'h0)};
    mem_cmd_v_i = 1'b1;
    step();
    mem_cmd_v_i = 1'b0;
    mem_hdr_ready_i = 1'b1;
    step();
    mem_hdr_ready_i = 1'b0;
    mem_data_ready_i = 1'b1;
    repeat (3) step();
    chk("mid_rst_beat3", mem_data_o, 64'h1f1e1d1c1b1a1918);
    reset_i = 1'b1;
    step();
    chk("mid_rst_hdr_v", 64'(mem_hdr_v_o), 64'd0);
    chk("mid_rst_data_v", 64'(mem_data_v_o), 64'd0);
    chk("mid_rst_last", 64'(mem_data_last_o), 64'd0);
    chk("mid_rst_ready0", 64'(mem_cmd_ready_o), 64'd0);
    reset_i = 1'b0;
    mem_data_ready_i = 1'b0;
    repeat (2) begin
      step();
      chk("post_rst_no_data", 64'(mem_data_v_o), 64'd0);
    end
    send_cmd(mk_hdr(e_cce_mem_uc_rd, e_mem_size_8, 40'h80_0000_b000, 16'h1), pat, 0, 100, 100);
    chk("post_rst_rd_beats", 64'(got_beats.size()), 64'd0);
    rdat = ~pat;
    send_cmd(mk_hdr(e_cce_mem_uc_wr, e_mem_size_16, 40'h80_0000_c000, 16'h2), rdat, 2, 100, 100);
    chk("post_rst_wr_count", 64'(got_beats.size()), 64'd2);
    if (got_beats.size() > 0) chk("post_rst_beat0", got_beats[0], ~64'h0706050403020100);

    // Randomized commands under random backpressure.
    for (int r = 0; r < 40; r++) begin
      t  = bp_cce_mem_cmd_type_e'($urandom_range(0, 5));
      sz = bp_cce_mem_req_size_e'($urandom_range(0, 6));
      a64 = {$urandom, $urandom};
      for (int j = 0; j < 16; j++) rdat[32*j +: 32] = $urandom;
      n = model_beats(t, sz);
      send_cmd(mk_hdr(t, sz, a64[39:0], 16'($urandom)), rdat, n,
               $urandom_range(30, 100), $urandom_range(30, 100));
      chk("rand_beat_count", 64'(got_beats.size()), 64'(n));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
